// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: instruction-address split and frame layout at the default 16-set geometry.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int IBYT_W = 2;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;
endpackage

// File: rtl/icache_frame_array.sv
// SETS-entry valid/tag/data store: one write port, asynchronous read, synchronous bulk valid clear.
// A clear on the same edge as a write still stores tag and data but leaves the frame invalid.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int TAG_W = 26,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output word_t            rdata
);
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            data [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            if (wen) begin
                tags[widx] <= wtag;
                data[widx] <= wdata;
            end
            if (clear)
                valid <= '0;
            else if (wen)
                valid[widx] <= 1'b1;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = data[ridx];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; hits are combinational, misses fetch one word via IDLE/FETCH.
// Memory request and address are held steady for the whole FETCH state, until iwait falls.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int PC_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                imemREN,
    input  logic [PC_WIDTH-1:0] imemaddr,
    output logic                ihit,
    output word_t               imemload,
    output logic                iREN,
    output logic [PC_WIDTH-1:0] iaddr,
    input  logic                iwait,
    input  word_t               iload,
    input  logic                flush
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_WIDTH - IBYT_W - IDX_W;

    typedef enum logic {IDLE, FETCH} icache_state_t;

    icache_state_t state, next_state;

    logic [PC_WIDTH-IBYT_W-1:0] miss_word;
    logic [IDX_W-1:0]           cur_idx, miss_idx;
    logic [TAG_W-1:0]           cur_tag, miss_tag, frame_tag;
    logic                       frame_valid, fill, unused_bytoff;

    assign cur_idx       = imemaddr[IDX_W+IBYT_W-1:IBYT_W];
    assign cur_tag       = imemaddr[PC_WIDTH-1:IDX_W+IBYT_W];
    assign miss_idx      = miss_word[IDX_W-1:0];
    assign miss_tag      = miss_word[PC_WIDTH-IBYT_W-1:IDX_W];
    assign unused_bytoff = ^imemaddr[IBYT_W-1:0];

    icache_frame_array #(.SETS(SETS), .TAG_W(TAG_W)) u_frames (
        .clk    (CLK),
        .rst_n  (nRST),
        .clear  (flush),
        .wen    (fill),
        .widx   (miss_idx),
        .wtag   (miss_tag),
        .wdata  (iload),
        .ridx   (cur_idx),
        .rvalid (frame_valid),
        .rtag   (frame_tag),
        .rdata  (imemload)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Only the word address is kept; the line is always fetched word-aligned.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            miss_word <= '0;
        else if (state == IDLE && next_state == FETCH)
            miss_word <= imemaddr[PC_WIDTH-1:IBYT_W];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (imemREN && !ihit) next_state = FETCH;
            FETCH:   if (!iwait)           next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ihit  = 1'b0;
        iREN  = 1'b0;
        iaddr = '0;
        fill  = 1'b0;
        case (state)
            IDLE: ihit = imemREN && frame_valid && (frame_tag == cur_tag) && !flush;
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, {IBYT_W{1'b0}}};
                fill  = !iwait;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: scripted memory responder, hand-computed miss costs and data.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    int          low;
    logic [31:0] got;
    logic        hit_seen;
    logic [31:0] seen_addr;
    int          ren_cnt;

    icache #(.SETS(16), .PC_WIDTH(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Called just after a falling edge. Holds the fetch until ihit, acting as memory with
    // 'waits' busy cycles per fill; optionally raises flush on the first fill edge.
    task automatic access(input logic [31:0] addr, input logic [31:0] data, input int waits,
                          input logic flush_fill, output int low_cycles, output logic [31:0] rd,
                          output logic hit, output logic [31:0] fetch_addr);
        int  cnt     = 0;
        bit  flushed = 0;
        bit  seen    = 0;
        low_cycles = 0;
        rd         = '0;
        hit        = 1'b0;
        fetch_addr = 32'hFFFF_FFFF;
        imemaddr   = addr;
        imemREN    = 1'b1;
        iwait      = 1'b1;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (ihit) begin
                rd  = imemload;
                hit = 1'b1;
                break;
            end
            low_cycles++;
            if (iREN) begin
                if (!seen) begin
                    fetch_addr = iaddr;
                    seen       = 1;
                end
                if (cnt < waits) begin
                    iwait = 1'b1;
                    cnt++;
                end else begin
                    iwait   = 1'b0;
                    iload   = data;
                    flush   = flush_fill && !flushed;
                    flushed = 1;
                    cnt     = 0;
                end
            end else begin
                iwait = 1'b1;
            end
            @(negedge CLK);
            flush = 1'b0;
        end
        iwait = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        flush    = 1'b0;

        @(negedge CLK); #1;
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_iREN", {31'b0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        imemaddr = 32'h100;
        ren_cnt  = 0;
        repeat (10) begin
            @(negedge CLK); #1;
            if (iREN) ren_cnt++;
        end
        @(negedge CLK);
        check("noreq_iREN_cycles", ren_cnt, 32'd0);

        access(32'h40, 32'h2001_0005, 3, 1'b0, low, got, hit_seen, seen_addr);
        check("cold_hit", {31'b0, hit_seen}, 32'd1);
        check("cold_low_cycles", low, 32'd5);
        check("cold_data", got, 32'h2001_0005);
        check("cold_iaddr", seen_addr, 32'h40);

        access(32'h40, 32'hDEAD_BEEF, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("rehit_low_cycles", low, 32'd0);
        check("rehit_data", got, 32'h2001_0005);

        access(32'h43, 32'hDEAD_BEEF, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("bytoff_low_cycles", low, 32'd0);
        check("bytoff_data", got, 32'h2001_0005);

        access(32'h04, 32'h1111_0004, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("fill04_low_cycles", low, 32'd2);
        check("fill04_data", got, 32'h1111_0004);

        access(32'h44, 32'h2222_0044, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("fill44_low_cycles", low, 32'd2);
        check("fill44_data", got, 32'h2222_0044);

        access(32'h04, 32'h1111_0004, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("evict04_low_cycles", low, 32'd2);
        check("evict04_iaddr", seen_addr, 32'h04);
        check("evict04_data", got, 32'h1111_0004);

        // Flush on the fill edge: first fill lost (IDLE, 2x FETCH), then a full refetch.
        access(32'h80, 32'h3333_0080, 1, 1'b1, low, got, hit_seen, seen_addr);
        check("flushfill_low_cycles", low, 32'd6);
        check("flushfill_data", got, 32'h3333_0080);

        access(32'h40, 32'h2001_0005, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("postflush40_low_cycles", low, 32'd2);
        access(32'h04, 32'h1111_0004, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("postflush04_low_cycles", low, 32'd2);

        imemaddr = 32'h200;
        imemREN  = 1'b1;
        iwait    = 1'b1;
        @(negedge CLK); #1;
        check("midfetch_iREN", {31'b0, iREN}, 32'd1);
        check("midfetch_iaddr", iaddr, 32'h200);
        nRST = 1'b0;
        #1;
        check("async_rst_iREN", {31'b0, iREN}, 32'd0);
        check("async_rst_iaddr", iaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        access(32'h0, 32'h0BAD_F00D, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("postrst0_low_cycles", low, 32'd2);
        check("postrst0_iaddr", seen_addr, 32'h0);
        check("postrst0_data", got, 32'h0BAD_F00D);
        access(32'h80, 32'h3333_0080, 0, 1'b0, low, got, hit_seen, seen_addr);
        check("postrst80_low_cycles", low, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's instruction-fetch port and the memory controller. Hits return the instruction combinationally in the same cycle. Misses fetch one word from memory through a two-state FSM, fill the frame, and then serve the access as a hit. The datapath stalls its PC on `ihit` low.

## Interface
Parameters:
- `SETS`, default 16: number of one-word frames; power of two, ≥2.
- `PC_WIDTH`, default 32: address width.

Ports:
- `CLK` in 1: clock. Sole clock, rising edge.
- `nRST` in 1: reset. Asynchronous, active-low.
- `imemREN` in 1: datapath fetch request.
- `imemaddr` in 32: datapath word address (PC); bits [1:0] ignored.
- `ihit` out 1: instruction valid this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: memory read request.
- `iaddr` out 32: memory read address.
- `iwait` in 1: memory busy; low marks the cycle `iload` is valid.
- `iload` in 32: memory read data.
- `flush` in 1: invalidate all frames (driven by halt or self-modifying code).

## Operation
- Address split: tag = `imemaddr[31:2+log2(SETS)]`, index = `imemaddr[1+log2(SETS):2]`, byte offset [1:0] ignored.
- Frame contents: valid bit, tag, and 32-bit data.
- Hit condition: `imemREN & valid[index] & tag match & state==IDLE`. On a hit, `ihit=1` and `imemload=data[index]`. No state change.
- `imemload` is always `data[index]`, whether or not the access hits. The datapath must qualify it with `ihit`.
- FSM IDLE:
  - `iREN=0`, `iaddr=0`.
  - If `imemREN` and not a hit: latch `imemaddr` into `miss_addr` and go to FETCH.
- FSM FETCH:
  - `iREN=1`, `iaddr={miss_addr[31:2],2'b00}`, `ihit=0`.
  - While `iwait=1`, stay in FETCH.
  - When `iwait=0`: write `iload` to `data[miss_index]`, write `miss_tag`, set valid, go to IDLE.
- After a fill, the next IDLE cycle re-evaluates the current `imemaddr`. That is a hit if the address is unchanged.
- Miss with `imemREN=0` starts nothing. A pending FETCH completes even if `imemREN` drops.
- `flush=1` clears all valid bits on the next edge, in any state.
  - If `flush` coincides with a fill-completion edge, the fill data is written but valid stays 0, because flush wins.
  - `ihit` is forced to 0 in any cycle where `flush=1`.
- Reset: all valid=0, tags and data=0, state IDLE, `miss_addr`=0.
  - Outputs after reset: `ihit=0`, `iREN=0`, `iaddr=0`, `imemload=0`.

## Timing
- Hit latency is 0 cycles, combinational from `imemaddr` to `ihit`/`imemload`.
- Miss cost: one cycle to detect and move to FETCH, plus N cycles of `iwait=1`, plus the fill edge. The hit then follows in the IDLE cycle after the fill.
- With a zero-wait memory, a miss costs 2 cycles with `ihit` low.
- The `iREN` and `iaddr` registered state holds stable for the whole FETCH state. The memory may rely on this.
- A reset edge mid-FETCH aborts the fetch immediately and returns to IDLE with all frames invalid. `iREN` drops asynchronously.

## Structure
- In `cpu_types_pkg`:
  - `icachef_t` address struct: tag, idx, bytoff.
  - `icache_frame_t` struct: valid, tag, data.
  - Constants `ITAG_W`, `IIDX_W`, `IBYT_W`.
- Ports connect through existing `datapath_cache_if` (`.icache` modport) and `caches_if` (`.icache` modport).
- One sub-module is natural: `icache_frame_array`, a SETS-entry storage array with one write port, async read, and a synchronous clear-valid input.
- The FSM state enum `icache_state_t` (IDLE, FETCH) is local to the module.

## Test plan
- Reset: assert `nRST=0` mid-FETCH. Required: `iREN=0` immediately; after release, a fetch of 0x0 misses with `ihit=0` and `iREN=1`, `iaddr=0x0`.
- Cold miss then hit: `imemaddr=0x40`, memory returns 0x2001_0005 after 3 `iwait` cycles. Required: `ihit=0` for 5 cycles, then `ihit=1`, `imemload=0x2001_0005`. A repeat access to 0x40 hits with no `iREN`.
- Conflict eviction with `SETS=16`: fill 0x04, then 0x44 (same index 1, different tag). Required: 0x04 misses again and `iaddr=0x04`.
- `imemREN=0` on an empty cache. Required: `iREN` stays 0 and the state stays IDLE for 10 cycles.
- Flush coinciding with fill completion at 0x80. Required: the next access to 0x80 misses; other previously valid frames also miss.
- Low address bits: `imemaddr=0x43` after filling 0x40. Required: `ihit=1` with the same data.
